pattern_line_sequencer: RTL
===========================

// Module: pattern_line_sequencer
// PURPOSE
//  Frame/line scheduler for the pattern Control FSM. Generates f_sync/sync pulses, the endFrame level and the
//  per-frame Mode/X configuration. Control then runs one line per sync and returns to IDLE on endFrame&endLine.
//  Config is written at any time into a shadow register and applied only at a frame boundary.
// PARAMETERS
//  LINE_W   11  width of line-count config/counter (lines per frame, max 2^LINE_W-1)
//  GAP_W    4   width of inter-line gap config/counter (idle clocks between endLine and next sync)
// PORTS
//  clk        in   1       16ns master clock
//  rst_n      in   1       async active-low reset
//  start      in   1       pulse: begin a frame (ignored while busy)
//  stop       in   1       pulse: abort frame at next line boundary
//  cfg_wr     in   1       write shadow config
//  cfg_mode   in   3       work mode (001 REGULAR .. 111 RAMP; 000 invalid)
//  cfg_x      in   2       deltaX code for RAMP
//  cfg_lines  in   LINE_W  lines per frame (0 treated as 1)
//  cfg_gap    in   GAP_W   idle clocks after endLine before next sync
//  endLine    in   1       from datapath: current line count finished
//  f_sync     out  1       first-sync pulse, high with sync on line 0 only
//  sync       out  1       one-cycle line-start pulse
//  endFrame   out  1       level: current line is the last of the frame
//  Mode       out  3       active mode to Control
//  X          out  2       active deltaX to Control
//  busy       out  1       frame in progress
//  frame_done out  1       one-cycle pulse after last endLine
//  cfg_err    out  1       sticky: start attempted with cfg_mode==000; cleared by next valid start
// BEHAVIOUR
//  Reset: all outputs 0; shadow config = {mode 001, x 00, lines 1, gap 0}; FSM IDLE; counters 0.
//  All outputs registered. FSM states:
//   IDLE  : start & shadow mode!=000 -> copy shadow to active Mode/X/lines/gap, line_cnt=0, busy=1 -> FIRST.
//           start & mode==000 -> set cfg_err, stay IDLE.
//   FIRST : f_sync=sync=1 for exactly one cycle (1 clk after start); endFrame=1 if lines<=1 -> RUN.
//   RUN   : wait endLine. On endLine: if endFrame -> DONE; else line_cnt++, gap_cnt=0 -> GAP.
//   GAP   : gap_cnt counts to active gap; at gap_cnt==gap -> LINE (gap=0 means LINE on next cycle).
//   LINE  : sync=1 (f_sync=0) one cycle; endFrame set if line_cnt==lines-1 or stop_pend -> RUN.
//   DONE  : frame_done=1 one cycle, busy=0, endFrame=0 -> IDLE (see CONFIGURATION).
//  endFrame: set on the cycle sync is issued for the last line and held until the endLine cycle, so that
//   Control sees endFrame&endLine together; cleared in DONE.
//  stop: sets stop_pend. If endFrame is already high, no effect (frame ends normally). Otherwise the next
//   issued line carries endFrame=1 (at most one extra line); stop in IDLE is ignored. stop_pend cleared in DONE.
//  cfg_wr: updates shadow only; active Mode/X/lines/gap never change mid-frame. cfg_wr on the same cycle as
//   start in IDLE: the new values are used (shadow bypass).
//  start while busy: ignored, no error. endLine outside RUN: ignored.
//  line_cnt saturates; it never wraps within a frame since lines<=2^LINE_W-1.
//  Async reset mid-frame: immediate IDLE, all outputs 0, shadow back to defaults.
// CONFIGURATION
//  PATSEQ_AUTO_REPEAT_EN defined: DONE pulses frame_done, then reloads active config from shadow and goes to
//   GAP (using the new gap), then FIRST semantics (f_sync+sync) -- continuous frames until stop. With auto
//   repeat, stop also suppresses the reload: DONE -> IDLE. mode==000 in shadow at reload -> cfg_err, IDLE.
//  Not defined: DONE always -> IDLE; a new start is required per frame.
// TESTING
//  1. cfg {mode 001,lines 3,gap 2}, start; endLine 5 clk after each sync -> f_sync&sync 1 clk after start,
//     two further sync-only pulses each 3 clk after endLine, endFrame high from 3rd sync to 3rd endLine,
//     frame_done 1 clk later, busy low.
//  2. lines=0 and lines=1 -> single f_sync&sync with endFrame already high; frame_done after first endLine.
//  3. Mid-frame cfg_wr {mode 111,x 10} during line 1 of 4 -> Mode/X stay 001/00 until frame end;
//     next start drives Mode=111, X=10.
//  4. lines=10, stop pulse during line 2 -> line 3 issued with endFrame=1, frame_done after its endLine,
//     exactly 4 syncs total; stop in IDLE -> no output change.
//  5. cfg_mode=000 then start -> no sync, cfg_err=1; valid mode + start -> frame runs, cfg_err=0.
//  6. PATSEQ_AUTO_REPEAT_EN, lines=2, gap=0 -> f_sync recurs every frame, frame_done per frame;
//     stop -> returns to IDLE after current frame; rst_n low mid-line -> all outputs 0 next edge-free.

Source files
------------

// File: rtl/pattern_line_sequencer.sv
// Frame/line scheduler for the pattern Control FSM: sync/f_sync pulses, endFrame, per-frame Mode/X.
// Optional continuous-frame operation is enabled by defining PATSEQ_AUTO_REPEAT_EN.
module pattern_line_sequencer #(
    parameter int LINE_W = 11,
    parameter int GAP_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              cfg_wr,
    input  logic [2:0]        cfg_mode,
    input  logic [1:0]        cfg_x,
    input  logic [LINE_W-1:0] cfg_lines,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic              endLine,
    output logic              f_sync,
    output logic              sync,
    output logic              endFrame,
    output logic [2:0]        Mode,
    output logic [1:0]        X,
    output logic              busy,
    output logic              frame_done,
    output logic              cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FIRST = 3'd1,
        S_RUN   = 3'd2,
        S_GAP   = 3'd3,
        S_LINE  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [LINE_W-1:0] LINE_ONE = {{(LINE_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W:0]    GAP_ONE  = {{GAP_W{1'b0}}, 1'b1};

    state_t state_q, state_d;

    logic [2:0]        sh_mode_q, sh_mode_d;
    logic [1:0]        sh_x_q, sh_x_d;
    logic [LINE_W-1:0] sh_lines_q, sh_lines_d;
    logic [GAP_W-1:0]  sh_gap_q, sh_gap_d;

    logic [2:0]        mode_q, mode_d;
    logic [1:0]        x_q, x_d;
    logic [LINE_W-1:0] lines_q, lines_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              stop_pend_q, stop_pend_d;
    logic              reload_q, reload_d;

    logic              f_sync_q, f_sync_d;
    logic              sync_q, sync_d;
    logic              end_frame_q, end_frame_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              cfg_err_q, cfg_err_d;

    // A write coinciding with a load is seen by that load.
    logic [2:0]        sel_mode;
    logic [1:0]        sel_x;
    logic [LINE_W-1:0] sel_lines;
    logic [GAP_W-1:0]  sel_gap;
    logic [GAP_W:0]    gap_cnt_inc;
    logic [LINE_W-1:0] last_idx;

    assign sel_mode    = cfg_wr ? cfg_mode  : sh_mode_q;
    assign sel_x       = cfg_wr ? cfg_x     : sh_x_q;
    assign sel_lines   = cfg_wr ? cfg_lines : sh_lines_q;
    assign sel_gap     = cfg_wr ? cfg_gap   : sh_gap_q;
    assign gap_cnt_inc = {1'b0, gap_cnt_q} + GAP_ONE;

    always_comb begin
        state_d      = state_q;
        sh_mode_d    = sel_mode;
        sh_x_d       = sel_x;
        sh_lines_d   = sel_lines;
        sh_gap_d     = sel_gap;
        mode_d       = mode_q;
        x_d          = x_q;
        lines_d      = lines_q;
        gap_d        = gap_q;
        line_cnt_d   = line_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        stop_pend_d  = stop_pend_q | (stop & (state_q != S_IDLE));
        reload_d     = reload_q;
        cfg_err_d    = cfg_err_q;
        f_sync_d     = 1'b0;
        sync_d       = 1'b0;
        frame_done_d = 1'b0;
        end_frame_d  = end_frame_q;
        busy_d       = 1'b0;
        last_idx     = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (sel_mode != 3'b000) begin
                        mode_d     = sel_mode;
                        x_d        = sel_x;
                        lines_d    = sel_lines;
                        gap_d      = sel_gap;
                        line_cnt_d = '0;
                        cfg_err_d  = 1'b0;
                        state_d    = S_FIRST;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_FIRST: state_d = S_RUN;
            S_RUN: begin
                if (endLine) begin
                    if (end_frame_q) begin
                        state_d = S_DONE;
                    end else begin
                        line_cnt_d = (&line_cnt_q) ? line_cnt_q : line_cnt_q + LINE_ONE;
                        gap_cnt_d  = '0;
                        state_d    = S_GAP;
                    end
                end
            end
            // GAP always lasts at least one clock, so gap 0 and 1 both give one idle clock.
            S_GAP: begin
                if (gap_cnt_inc >= {1'b0, gap_q}) begin
                    state_d = reload_q ? S_FIRST : S_LINE;
                end else begin
                    gap_cnt_d = gap_cnt_inc[GAP_W-1:0];
                end
            end
            S_LINE: state_d = S_RUN;
            S_DONE: begin
                stop_pend_d = 1'b0;
`ifdef PATSEQ_AUTO_REPEAT_EN
                if (stop_pend_q | stop) begin
                    state_d = S_IDLE;
                end else if (sel_mode == 3'b000) begin
                    cfg_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    mode_d     = sel_mode;
                    x_d        = sel_x;
                    lines_d    = sel_lines;
                    gap_d      = sel_gap;
                    line_cnt_d = '0;
                    gap_cnt_d  = '0;
                    reload_d   = 1'b1;
                    state_d    = S_GAP;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so every output comes straight from a flop.
        last_idx = (lines_d == '0) ? '0 : lines_d - LINE_ONE;
        case (state_d)
            S_FIRST: begin
                f_sync_d    = 1'b1;
                sync_d      = 1'b1;
                reload_d    = 1'b0;
                line_cnt_d  = '0;
                end_frame_d = (lines_d <= LINE_ONE) | stop_pend_d;
            end
            S_LINE: begin
                sync_d      = 1'b1;
                end_frame_d = (line_cnt_d >= last_idx) | stop_pend_d;
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                end_frame_d  = 1'b0;
            end
            S_IDLE: end_frame_d = 1'b0;
            default: ;
        endcase

        busy_d = (state_d == S_FIRST) || (state_d == S_RUN) ||
                 (state_d == S_GAP)   || (state_d == S_LINE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sh_mode_q    <= 3'b001;
            sh_x_q       <= 2'b00;
            sh_lines_q   <= LINE_ONE;
            sh_gap_q     <= '0;
            mode_q       <= 3'b000;
            x_q          <= 2'b00;
            lines_q      <= '0;
            gap_q        <= '0;
            line_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            stop_pend_q  <= 1'b0;
            reload_q     <= 1'b0;
            f_sync_q     <= 1'b0;
            sync_q       <= 1'b0;
            end_frame_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_mode_q    <= sh_mode_d;
            sh_x_q       <= sh_x_d;
            sh_lines_q   <= sh_lines_d;
            sh_gap_q     <= sh_gap_d;
            mode_q       <= mode_d;
            x_q          <= x_d;
            lines_q      <= lines_d;
            gap_q        <= gap_d;
            line_cnt_q   <= line_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            stop_pend_q  <= stop_pend_d;
            reload_q     <= reload_d;
            f_sync_q     <= f_sync_d;
            sync_q       <= sync_d;
            end_frame_q  <= end_frame_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign f_sync     = f_sync_q;
    assign sync       = sync_q;
    assign endFrame   = end_frame_q;
    assign Mode       = mode_q;
    assign X          = x_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign cfg_err    = cfg_err_q;

endmodule
